// File: rtl/ttl_count_pkg.sv
// Shared definitions for the counter-chain sequencer: command op codes and
// the sequencer state encoding.
package ttl_count_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_SKIP = 2'b11;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        INC,
        SKIP1,
        SKIP2,
        LOAD,
        CHECK
    } state_t;

endpackage

// File: rtl/ttl_count_sequencer_if.sv
// Command handshake between the CPU control unit (master) and the counter
// sequencer (slave).
interface ttl_count_sequencer_if #(
    parameter int W = 16
);
    logic         cmd_valid;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         cmd_ready;
    logic         busy;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready,
        input  busy
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready,
        output busy
    );
endinterface

// File: rtl/ttl_count_sequencer.sv
// Control sequencer for a cascade of 4-bit synchronous counter slices.
// The FSM state advances on acceptance; the slice pins are driven from a
// one-cycle-delayed copy of the state (pin_state), so every pin is a pure
// registered decode and the counter sees each operation one edge later.
module ttl_count_sequencer
    import ttl_count_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic            clock,
    input  logic            reset,
    ttl_count_sequencer_if.slave cmd,
    output logic            cnt_clr_n,
    output logic            cnt_load_n,
    output logic            cnt_enp,
    output logic            cnt_ent,
    output logic [W-1:0]    cnt_d,
    input  logic [W-1:0]    cnt_q,
    input  logic            cnt_rco,
    output logic            wrapped,
    output logic            load_err
);

    state_t       state;
    state_t       next_state;
    state_t       pin_state;
    logic [W-1:0] data_q;
    logic         ready;
    logic         accept;
    logic         counting;

    // Ready only once both the FSM and the pins have settled back in IDLE,
    // which guarantees the previous operation has fully reached the chain.
    assign ready         = (state == IDLE) && (pin_state == IDLE);
    assign accept        = cmd.cmd_valid && ready;
    assign counting      = (pin_state == INC) || (pin_state == SKIP1) || (pin_state == SKIP2);
    assign cmd.cmd_ready = ready;
    assign cmd.busy      = !ready;

    // State register plus the delayed pin-phase copy of the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= CLEAR;
            pin_state <= CLEAR;
        end else begin
            state     <= next_state;
            pin_state <= state;
        end
    end

    // Next-state decode; commands are only looked at when accepted in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            CLEAR: next_state = IDLE;
            IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_INC:  next_state = INC;
                        OP_LOAD: next_state = LOAD;
                        OP_SKIP: next_state = SKIP1;
                        default: next_state = IDLE;
                    endcase
                end
            end
            INC:     next_state = IDLE;
            SKIP1:   next_state = SKIP2;
            SKIP2:   next_state = IDLE;
            LOAD:    next_state = CHECK;
            CHECK:   next_state = IDLE;
            default: next_state = CLEAR;
        endcase
    end

    // Slice control pins decoded from the pin phase only.
    always_comb begin
        cnt_clr_n  = 1'b1;
        cnt_load_n = 1'b1;
        cnt_enp    = 1'b0;
        cnt_ent    = 1'b0;
        cnt_d      = data_q;
        case (pin_state)
            CLEAR: begin
                cnt_clr_n = 1'b0;
                cnt_d     = '0;
            end
            LOAD:  cnt_load_n = 1'b0;
            INC, SKIP1, SKIP2: begin
                cnt_enp = 1'b1;
                cnt_ent = 1'b1;
            end
            default: ;
        endcase
    end

    // Load value latch, sticky wrap flag and load read-back check.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q   <= '0;
            wrapped  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            if (accept && (cmd.cmd_op == OP_LOAD)) begin
                data_q  <= cmd.cmd_data;
                wrapped <= 1'b0;
            end else if (counting && cnt_rco) begin
                wrapped <= 1'b1;
            end
            if ((pin_state == CHECK) && (cnt_q != data_q)) begin
                load_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ttl_count_sequencer.sv
// Bench for ttl_count_sequencer with a behavioural model of the cascaded
// 4-bit counter slices (async clear, sync load, enp/ent, rco cascade).
module tb_ttl_count_sequencer;
    import ttl_count_pkg::*;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clock;
    logic         reset;
    logic         cnt_clr_n;
    logic         cnt_load_n;
    logic         cnt_enp;
    logic         cnt_ent;
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;
    logic         cnt_rco;
    logic         wrapped;
    logic         load_err;

    logic         tb_own;
    logic         tb_load_n;
    logic [W-1:0] stuck0;
    logic         chain_clr_n;
    logic         chain_load_n;
    logic         chain_enp;
    logic         chain_ent;
    logic [W-1:0] chain_d;
    logic [NIBBLES:0] ent_chain;

    int checks   = 0;
    int failures = 0;

    ttl_count_sequencer_if #(.W(W)) cmd_bus ();

    ttl_count_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd        (cmd_bus),
        .cnt_clr_n  (cnt_clr_n),
        .cnt_load_n (cnt_load_n),
        .cnt_enp    (cnt_enp),
        .cnt_ent    (cnt_ent),
        .cnt_d      (cnt_d),
        .cnt_q      (cnt_q),
        .cnt_rco    (cnt_rco),
        .wrapped    (wrapped),
        .load_err   (load_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bench can take over the chain pins to pre-load it before reset.
    assign chain_clr_n  = tb_own ? 1'b1 : cnt_clr_n;
    assign chain_load_n = tb_own ? tb_load_n : cnt_load_n;
    assign chain_enp    = tb_own ? 1'b0 : cnt_enp;
    assign chain_ent    = tb_own ? 1'b0 : cnt_ent;
    assign chain_d      = tb_own ? 16'h1234 : cnt_d;
    assign ent_chain[0] = chain_ent;
    assign cnt_rco      = ent_chain[NIBBLES];

    for (genvar i = 0; i < NIBBLES; i++) begin : g_slice
        logic [3:0] q;
        // One 4-bit synchronous counter slice with async active-low clear.
        always_ff @(posedge clock or negedge chain_clr_n) begin
            if (!chain_clr_n)
                q <= 4'h0;
            else if (!chain_load_n)
                q <= chain_d[4*i +: 4];
            else if (chain_enp && ent_chain[i])
                q <= q + 4'h1;
        end
        assign cnt_q[4*i +: 4] = q & ~stuck0[4*i +: 4];
        assign ent_chain[i+1]  = ent_chain[i] && (q == 4'hF);
    end

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] data;
        logic [W-1:0] exp_q;
        logic         exp_wrapped;
        logic         exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitReady(input string tag);
        int n = 0;
        while (cmd_bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (cmd_bus.cmd_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_ready_timeout: got %b, expected 1", tag, cmd_bus.cmd_ready);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] data);
        waitReady("pre");
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_data  = data;
        tick();
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = OP_NOP;
        cmd_bus.cmd_data  = '0;
        waitReady("post");
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] data);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_data  = data;
        tick();
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = OP_NOP;
        cmd_bus.cmd_data  = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{OP_LOAD, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0};
        vecs[1]  = '{OP_INC,  16'h0000, 16'h1000, 1'b0, 1'b0};
        vecs[2]  = '{OP_NOP,  16'h5555, 16'h1000, 1'b0, 1'b0};
        vecs[3]  = '{OP_SKIP, 16'h0000, 16'h1002, 1'b0, 1'b0};
        vecs[4]  = '{OP_LOAD, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        vecs[5]  = '{OP_INC,  16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{OP_INC,  16'h0000, 16'h0001, 1'b1, 1'b0};
        vecs[7]  = '{OP_LOAD, 16'h00FE, 16'h00FE, 1'b0, 1'b0};
        vecs[8]  = '{OP_SKIP, 16'h0000, 16'h0100, 1'b0, 1'b0};
        vecs[9]  = '{OP_LOAD, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
        vecs[10] = '{OP_SKIP, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{OP_LOAD, 16'h0001, 16'h0001, 1'b0, 1'b0};
        vecs[12] = '{OP_LOAD, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        vecs[13] = '{OP_SKIP, 16'h0000, 16'h0001, 1'b1, 1'b0};

        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = OP_NOP;
        cmd_bus.cmd_data  = '0;
        stuck0            = '0;
        tb_own            = 1'b1;
        tb_load_n         = 1'b0;
        reset             = 1'b1;

        // Pre-load the chain, then hand it to the DUT while in reset.
        tick();
        checkOutput("preload_q", cnt_q, 16'h1234);
        tb_own    = 1'b0;
        tb_load_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_clr_n", cnt_clr_n, 1'b0);
            checkOutput("rst_ready", cmd_bus.cmd_ready, 1'b0);
        end
        checkOutput("rst_q", cnt_q, 16'h0000);
        checkOutput("rst_wrapped", wrapped, 1'b0);
        checkOutput("rst_load_err", load_err, 1'b0);
        reset = 1'b0;
        tick();
        checkOutput("clear_hold_clr_n", cnt_clr_n, 1'b0);
        checkOutput("clear_hold_ready", cmd_bus.cmd_ready, 1'b0);
        tick();
        checkOutput("idle_clr_n", cnt_clr_n, 1'b1);
        checkOutput("idle_ready", cmd_bus.cmd_ready, 1'b1);
        checkOutput("idle_busy", cmd_bus.busy, 1'b0);

        // LOAD 0xBEEF latency: load pulse in N+1 only, ready back at N+3.
        issue(OP_LOAD, 16'hBEEF);
        checkOutput("ld_n0_load_n", cnt_load_n, 1'b1);
        checkOutput("ld_n0_busy", cmd_bus.busy, 1'b1);
        tick();
        checkOutput("ld_n1_load_n", cnt_load_n, 1'b0);
        checkOutput("ld_n1_d", cnt_d, 16'hBEEF);
        checkOutput("ld_n1_q", cnt_q, 16'h0000);
        tick();
        checkOutput("ld_n2_load_n", cnt_load_n, 1'b1);
        checkOutput("ld_n2_q", cnt_q, 16'hBEEF);
        checkOutput("ld_n2_ready", cmd_bus.cmd_ready, 1'b0);
        tick();
        checkOutput("ld_n3_ready", cmd_bus.cmd_ready, 1'b1);
        checkOutput("ld_n3_load_err", load_err, 1'b0);

        // Table of whole commands with expected end state.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].data);
            checkOutput($sformatf("vec%0d_q", i), cnt_q, vecs[i].exp_q);
            checkOutput($sformatf("vec%0d_wrapped", i), wrapped, vecs[i].exp_wrapped);
            checkOutput($sformatf("vec%0d_load_err", i), load_err, vecs[i].exp_err);
        end

        // SKIP from 0xFFFE cycle by cycle, then LOAD clears wrapped.
        applyStimulus(OP_LOAD, 16'hFFFE);
        issue(OP_SKIP, '0);
        checkOutput("sk_n0_enp", cnt_enp, 1'b0);
        tick();
        checkOutput("sk_n1_enp", cnt_enp, 1'b1);
        checkOutput("sk_n1_ent", cnt_ent, 1'b1);
        checkOutput("sk_n1_q", cnt_q, 16'hFFFE);
        tick();
        checkOutput("sk_n2_q", cnt_q, 16'hFFFF);
        checkOutput("sk_n2_wrapped", wrapped, 1'b0);
        checkOutput("sk_n2_ready", cmd_bus.cmd_ready, 1'b0);
        tick();
        checkOutput("sk_n3_q", cnt_q, 16'h0000);
        checkOutput("sk_n3_wrapped", wrapped, 1'b1);
        checkOutput("sk_n3_ready", cmd_bus.cmd_ready, 1'b1);
        checkOutput("sk_n3_enp", cnt_enp, 1'b0);
        applyStimulus(OP_LOAD, 16'h0001);
        checkOutput("sk_reload_wrapped", wrapped, 1'b0);

        // Stuck-at-0 bit in slice 2 makes the load read-back fail.
        stuck0 = 16'h0100;
        applyStimulus(OP_LOAD, 16'h0F00);
        checkOutput("stuck_q", cnt_q, 16'h0E00);
        checkOutput("stuck_load_err", load_err, 1'b1);
        stuck0 = '0;
        applyStimulus(OP_INC, '0);
        checkOutput("stuck_after_q", cnt_q, 16'h0F01);
        checkOutput("stuck_sticky_err", load_err, 1'b1);

        // Reset during SKIP1 aborts the skip entirely.
        applyStimulus(OP_LOAD, 16'h0005);
        issue(OP_SKIP, '0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("abort_enp", cnt_enp, 1'b0);
            checkOutput("abort_clr_n", cnt_clr_n, 1'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("abort_post_enp", cnt_enp, 1'b0);
        end
        checkOutput("abort_q", cnt_q, 16'h0000);
        checkOutput("abort_wrapped", wrapped, 1'b0);
        checkOutput("abort_load_err", load_err, 1'b0);
        checkOutput("abort_ready", cmd_bus.cmd_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ttl_count_sequencer.md
Name: ttl_count_sequencer

Overview:
- Upstream control stage for a cascade of 4-bit synchronous counter slices. Each slice has active-low load, active-low async clear, ent/enp enables, 4-bit d, q and rco.
- Accepts increment / load / skip commands over a valid-ready handshake and turns each into the slice control pins over a defined number of cycles.
- Clears the chain after reset, checks every load by reading the chain's q back, and flags carry-out wrap-around.
- Sits between the CPU control unit (program-counter commands) and the counter chain.

Parameters:
- NIBBLES, 4, number of cascaded 4-bit slices. Counter width W = 4*NIBBLES.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_op  in  2  00 NOP, 01 INC, 10 LOAD, 11 SKIP (increment by 2).
- cmd_data  in  W  load value; used only for LOAD.
- cmd_ready  out  1  sequencer can accept a command.
- busy  out  1  command in progress; equals the inverse of cmd_ready.
- cnt_clr_n  out  1  to every slice's clr, active low.
- cnt_load_n  out  1  to every slice's load, active low.
- cnt_enp  out  1  to every slice's enp.
- cnt_ent  out  1  to slice 0's ent. Higher slices' ent is chained from rco outside this block.
- cnt_d  out  W  to the slices' d inputs; nibble i goes to slice i.
- cnt_q  in  W  read-back from the slices' q outputs.
- cnt_rco  in  1  rco of the last slice.
- wrapped  out  1  sticky: the chain rolled over from all-ones.
- load_err  out  1  sticky: load read-back mismatch.

Behaviour:
- Reset is synchronous and active-high.
  - While reset is high: state = CLEAR, cnt_clr_n=0, cnt_load_n=1, cnt_enp=0, cnt_ent=0, cnt_d=0, cmd_ready=0, wrapped=0, load_err=0, and the internal latched value data_q=0.
  - Reset asserted in any state, including mid-command, aborts that command; no partial operation completes.
- States:
  - CLEAR: cnt_clr_n=0 for exactly one cycle after reset deasserts, then IDLE.
  - IDLE: cmd_ready=1, all control pins inactive.
    - A command is accepted on a clock edge with cmd_valid&cmd_ready.
    - NOP: accepted, stays in IDLE.
    - INC: go to INC.
    - LOAD: data_q<=cmd_data, wrapped<=0, go to LOAD.
    - SKIP: go to SKIP1.
  - INC: cnt_enp=cnt_ent=1 for one cycle, then IDLE.
  - SKIP1, SKIP2: each drives cnt_enp=cnt_ent=1 for one cycle. SKIP1 goes to SKIP2; SKIP2 goes to IDLE.
  - LOAD: cnt_load_n=0, cnt_d=data_q for one cycle, then CHECK.
  - CHECK: compare cnt_q with data_q. On mismatch set load_err. Then IDLE.
- Outputs are registered or decoded from state only; no combinational path from cmd_* to the cnt_* pins. cnt_d holds data_q in every state except CLEAR.
- Latency, with acceptance at edge N:
  - INC: counter changes at N+2; cmd_ready high again from N+2.
  - SKIP: counter changes at N+2 and N+3; ready from N+3.
  - LOAD: counter loads at N+2, checked at N+3; ready from N+3.
- Wrap detection: in INC, SKIP1 or SKIP2, if cnt_rco=1 at the clock edge, set wrapped.
  - wrapped stays set until reset or until a LOAD is accepted.
  - SKIP from all-ones or from all-ones minus 1 sets wrapped.
- load_err clears only on reset.
- cmd_op, cmd_data and cmd_valid are ignored when cmd_ready=0. The source must hold its command until it is accepted.
- Counter arithmetic is modulo 2^W; this block never computes the sum itself.

Decomposition:
- Shared package ttl_count_pkg holds:
  - op code constants OP_NOP, OP_INC, OP_LOAD, OP_SKIP;
  - the state enum CLEAR, IDLE, INC, SKIP1, SKIP2, LOAD, CHECK.
- No sub-module inside this block.
- The bench instantiates NIBBLES counter slices as the model of the chain, with ent cascaded through rco.

Test Plan:
- Reset for 3 cycles with the chain pre-loaded to 0x1234 -> cnt_clr_n low during reset plus one cycle; q=0x0000; cmd_ready rises 1 cycle after reset falls.
- LOAD 0xBEEF accepted at N -> cnt_load_n low only in cycle N+1; q=0xBEEF after edge N+2; load_err=0; cmd_ready=1 at N+3.
- LOAD 0x0FFF, then INC -> q=0x1000 (carry crosses slices 0-2); wrapped=0.
- LOAD 0xFFFE, then SKIP -> q=0xFFFF then 0x0000; wrapped=1; a following LOAD 0x0001 clears wrapped.
- Bench forces a stuck bit in slice 2 and issues LOAD 0x0F00 -> load_err=1 in CHECK and stays 1 until reset.
- Reset asserted in SKIP1 after LOAD 0x0005 -> q ends at 0x0000, not 0x0007; no SKIP2 enable pulse; wrapped=0.
